// File: rtl/abus_grant_ctrl.sv
// abus_grant_ctrl: registers the grant returned by the combinational abus_rr
// arbiter, holds it for the whole bus transaction (bounded by HOLD_MAX cycles)
// and rotates the one-hot arbiter priority past the owner on release.
module abus_grant_ctrl #(
    parameter int N        = 8,
    parameter int HOLD_MAX = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] m_req,
    input  logic [N-1:0] m_last,
    output logic [N-1:0] rr_req,
    output logic [N-1:0] rr_prio,
    input  logic [N-1:0] rr_grant,
    output logic [N-1:0] m_grant,
    output logic         bus_busy,
    output logic         timeout,
    output logic         grant_err
);

    localparam int CW = $clog2(HOLD_MAX);
    localparam logic [N-1:0]  LSB1    = {{(N-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_END = CW'(HOLD_MAX - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [N-1:0]  r_grant, w_grant_nxt;
    logic [N-1:0]  r_prio, w_prio_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_tmo, w_tmo_nxt;
    logic          r_err, w_err_nxt;

    logic          w_onehot;
    logic          w_last_hit;
    logic          w_req_drop;
    logic          w_hold_end;

    // A grant is only accepted if the arbiter returned exactly one bit.
    assign w_onehot   = (rr_grant != '0) && ((rr_grant & (rr_grant - LSB1)) == '0);
    // Only the owner's bits matter; other masters' m_last/m_req are ignored.
    assign w_last_hit = |(m_last & r_grant);
    assign w_req_drop = ~|(m_req & r_grant);
    assign w_hold_end = (r_cnt == CNT_END);

    // Requests reach the arbiter only while the bus is free.
    assign rr_req    = (r_state == IDLE) ? m_req : '0;
    assign rr_prio   = r_prio;
    assign m_grant   = r_grant;
    assign bus_busy  = r_busy;
    assign timeout   = r_tmo;
    assign grant_err = r_err;

    // Next-state, grant/priority/counter updates and one-cycle pulses.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_prio_nxt  = r_prio;
        w_cnt_nxt   = r_cnt;
        w_tmo_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_onehot) begin
                    w_grant_nxt = rr_grant;
                    w_cnt_nxt   = '0;
                    w_state_nxt = GRANT;
                end else if (rr_grant != '0) begin
                    w_err_nxt = 1'b1;
                end
            end
            GRANT: begin
                if (w_last_hit || w_req_drop || w_hold_end) begin
                    w_grant_nxt = '0;
                    // Owner becomes lowest priority: its left neighbour goes first.
                    w_prio_nxt  = {r_grant[N-2:0], r_grant[N-1]};
                    w_state_nxt = RELEASE;
                    // A normal end on the last allowed cycle is not a timeout.
                    w_tmo_nxt   = !w_last_hit && !w_req_drop;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            RELEASE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        w_busy_nxt = (w_state_nxt == GRANT);
    end

    // State and registered outputs; reset abandons any transaction at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_prio  <= LSB1;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_tmo   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_prio  <= w_prio_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
            r_tmo   <= w_tmo_nxt;
            r_err   <= w_err_nxt;
        end
    end

endmodule

// File: tb/tb_abus_grant_ctrl.sv
// Testbench for abus_grant_ctrl: directed scenarios plus randomized traffic,
// checked against a transaction-level model of owner / hold time / priority.
module tb_abus_grant_ctrl;

    localparam int N  = 8;
    localparam int HM = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] m_req, m_last, rr_req, rr_prio, rr_grant, m_grant;
    logic         bus_busy, timeout, grant_err;
    logic         force_en;
    logic [N-1:0] force_val;

    int cmp_cnt  = 0;
    int fail_cnt = 0;

    // Model: owner index (-1 = bus free), cycles owned so far, dead cycle flag,
    // index of the highest-priority master, and expected pulses.
    int m_owner, m_held, m_pidx;
    bit m_dead, m_tmo, m_err;

    always #5 clk = ~clk;

    // Stand-in for abus_rr: first requester at or after the priority position.
    function automatic logic [N-1:0] arb(input logic [N-1:0] req, input logic [N-1:0] prio);
        int p = 0;
        logic [N-1:0] g = '0;
        for (int i = 0; i < N; i++) if (prio[i]) p = i;
        for (int i = 0; i < N; i++) begin
            int j = (p + i) % N;
            if (req[j] && g == '0) g[j] = 1'b1;
        end
        return g;
    endfunction

    assign rr_grant = force_en ? force_val : arb(rr_req, rr_prio);

    abus_grant_ctrl #(.N(N), .HOLD_MAX(HM)) dut (
        .clk(clk), .rst(rst), .m_req(m_req), .m_last(m_last),
        .rr_req(rr_req), .rr_prio(rr_prio), .rr_grant(rr_grant),
        .m_grant(m_grant), .bus_busy(bus_busy), .timeout(timeout),
        .grant_err(grant_err)
    );

    function automatic logic [2*N+2:0] exp_vec();
        logic [N-1:0] g = '0;
        logic [N-1:0] p = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        p[m_pidx] = 1'b1;
        return {g, p, (m_owner >= 0), m_tmo, m_err};
    endfunction

    function automatic logic [2*N+2:0] obs_vec();
        return {m_grant, rr_prio, bus_busy, timeout, grant_err};
    endfunction

    task automatic model_reset();
        m_owner = -1; m_held = 0; m_pidx = 0;
        m_dead = 0; m_tmo = 0; m_err = 0;
    endtask

    // One clock of the model from the inputs present before the edge.
    task automatic model_step();
        logic [N-1:0] g, p;
        bit nat;
        m_tmo = 0; m_err = 0;
        if (rst) model_reset();
        else if (m_dead) m_dead = 0;
        else if (m_owner < 0) begin
            p = '0; p[m_pidx] = 1'b1;
            g = force_en ? force_val : arb(m_req, p);
            if ($countones(g) == 1) begin
                for (int i = 0; i < N; i++) if (g[i]) m_owner = i;
                m_held = 1;
            end else if (g != '0) m_err = 1;
        end else begin
            nat = m_last[m_owner] || !m_req[m_owner];
            if (nat || m_held == HM) begin
                m_tmo   = !nat;
                m_pidx  = (m_owner + 1) % N;
                m_owner = -1;
                m_dead  = 1;
            end else m_held++;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1; m_req = '0; m_last = '0; force_en = 1'b0; force_val = '0;
        model_reset();
        #2;
        cmp_cnt++;
        if (obs_vec() !== {8'h00, 8'h01, 3'b000}) begin
            fail_cnt++; $display("FAIL reset_init got=%h exp=%h", obs_vec(), {8'h00, 8'h01, 3'b000});
        end
        rst = 1'b0;
        m_req = 8'h01;
        tick();
        cmp_cnt++;
        if (obs_vec() !== exp_vec() || m_grant !== 8'h01) begin
            fail_cnt++; $display("FAIL reset_pregrant got=%h exp=%h", obs_vec(), exp_vec());
        end
        #2;
        rst = 1'b1;
        #1;
        cmp_cnt++;
        if ({m_grant, rr_prio, bus_busy, timeout} !== {8'h00, 8'h01, 2'b00}) begin
            fail_cnt++; $display("FAIL reset_async got=%h exp=%h", {m_grant, rr_prio, bus_busy, timeout}, {8'h00, 8'h01, 2'b00});
        end
        model_reset();
        rst = 1'b0;
        m_req = '0;
        tick();
        cmp_cnt++;
        if (obs_vec() !== exp_vec()) begin
            fail_cnt++; $display("FAIL reset_after got=%h exp=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_single();
        int gcnt = 0;
        apply_reset();
        m_req = 8'h04; m_last = '0;
        for (int c = 1; c <= 6; c++) begin
            if (c == 4) m_last = 8'h04;
            if (c == 5) begin m_req = '0; m_last = '0; end
            tick();
            if (m_grant == 8'h04) gcnt++;
            cmp_cnt++;
            if (obs_vec() !== exp_vec()) begin
                fail_cnt++; $display("FAIL single_c%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
        end
        cmp_cnt++;
        if (gcnt != 3 || rr_prio !== 8'h08) begin
            fail_cnt++; $display("FAIL single_hold got=%0d/%h exp=3/08", gcnt, rr_prio);
        end
    endtask

    task automatic test_all();
        int k = 0, last_c = 0;
        logic [N-1:0] prev = '0, want;
        apply_reset();
        m_req = 8'hFF; m_last = 8'hFF;
        for (int c = 0; c < 27; c++) begin
            tick();
            cmp_cnt++;
            if (obs_vec() !== exp_vec() || $countones(m_grant) > 1) begin
                fail_cnt++; $display("FAIL all_c%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            if (m_grant != '0 && prev == '0) begin
                want = '0; want[k % N] = 1'b1;
                cmp_cnt++;
                if (m_grant !== want || (k > 0 && c - last_c != 3)) begin
                    fail_cnt++; $display("FAIL all_seq%0d got=%h@%0d exp=%h@%0d", k, m_grant, c, want, last_c + 3);
                end
                last_c = c; k++;
            end
            prev = m_grant;
        end
        cmp_cnt++;
        if (k != 9) begin
            fail_cnt++; $display("FAIL all_count got=%0d exp=9", k);
        end
        m_req = '0; m_last = '0;
    endtask

    task automatic test_timeout();
        for (int v = 0; v < 2; v++) begin
            int gcnt = 0, tcnt = 0;
            apply_reset();
            m_req = 8'h02; m_last = '0;
            for (int c = 0; c < 20; c++) begin
                if (v == 1 && c == 16) m_last = 8'h02;
                tick();
                if (m_grant == 8'h02) gcnt++;
                if (timeout) tcnt++;
                cmp_cnt++;
                if (obs_vec() !== exp_vec()) begin
                    fail_cnt++; $display("FAIL tmo%0d_c%0d got=%h exp=%h", v, c, obs_vec(), exp_vec());
                end
                if (c == 16) begin m_req = '0; m_last = '0; end
            end
            cmp_cnt++;
            if (gcnt != 16 || tcnt != (v == 0 ? 1 : 0) || rr_prio !== 8'h04) begin
                fail_cnt++; $display("FAIL tmo%0d_total got=%0d/%0d/%h exp=16/%0d/04", v, gcnt, tcnt, rr_prio, (v == 0 ? 1 : 0));
            end
        end
    endtask

    task automatic test_withdraw();
        logic [N-1:0] rq [8] = '{8'h08, 8'h08, 8'h11, 8'h11, 8'h11, 8'h01, 8'h01, 8'h01};
        logic [N-1:0] ls [8] = '{8'h08, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        apply_reset();
        for (int t = 0; t < 8; t++) begin
            m_req = rq[t]; m_last = ls[t];
            tick();
            cmp_cnt++;
            if (obs_vec() !== exp_vec()) begin
                fail_cnt++; $display("FAIL wd_t%0d got=%h exp=%h", t, obs_vec(), exp_vec());
            end
            if (t == 3) begin
                cmp_cnt++;
                if (m_grant !== 8'h10) begin
                    fail_cnt++; $display("FAIL wd_owner got=%h exp=10", m_grant);
                end
            end
            if (t == 5) begin
                cmp_cnt++;
                if ({m_grant, rr_prio, timeout} !== {8'h00, 8'h20, 1'b0}) begin
                    fail_cnt++; $display("FAIL wd_release got=%h exp=%h", {m_grant, rr_prio, timeout}, {8'h00, 8'h20, 1'b0});
                end
            end
            if (t == 7) begin
                cmp_cnt++;
                if (m_grant !== 8'h01) begin
                    fail_cnt++; $display("FAIL wd_next got=%h exp=01", m_grant);
                end
            end
        end
        m_req = '0;
    endtask

    task automatic test_error();
        apply_reset();
        m_req = '0; m_last = '0;
        force_en = 1'b1; force_val = 8'h03;
        tick();
        cmp_cnt++;
        if (obs_vec() !== exp_vec() || grant_err !== 1'b1 || m_grant !== 8'h00) begin
            fail_cnt++; $display("FAIL err_pulse got=%h exp=%h", obs_vec(), exp_vec());
        end
        force_en = 1'b0;
        tick();
        cmp_cnt++;
        if (obs_vec() !== exp_vec() || grant_err !== 1'b0) begin
            fail_cnt++; $display("FAIL err_clear got=%h exp=%h", obs_vec(), exp_vec());
        end
        m_req = 8'h40;
        tick();
        cmp_cnt++;
        if (obs_vec() !== exp_vec() || m_grant !== 8'h40) begin
            fail_cnt++; $display("FAIL err_grant got=%h exp=%h", obs_vec(), exp_vec());
        end
        #2;
        rst = 1'b1;
        tick();
        cmp_cnt++;
        if (obs_vec() !== exp_vec() || m_grant !== 8'h00 || bus_busy !== 1'b0) begin
            fail_cnt++; $display("FAIL err_rst got=%h exp=%h", obs_vec(), exp_vec());
        end
        rst = 1'b0;
        #1;
        cmp_cnt++;
        if (rr_req !== 8'h40) begin
            fail_cnt++; $display("FAIL err_idle got=%h exp=40", rr_req);
        end
        m_req = '0;
    endtask

    task automatic test_random();
        apply_reset();
        m_req = N'($urandom);
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 7) == 0) m_req = N'($urandom);
            if (c < 200) m_last = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
            else         m_last = ($urandom_range(0, 40) == 0) ? N'($urandom) : '0;
            #1;
            cmp_cnt++;
            if (rr_req !== ((m_owner < 0 && !m_dead) ? m_req : '0)) begin
                fail_cnt++; $display("FAIL rnd_rrreq_c%0d got=%h req=%h", c, rr_req, m_req);
            end
            tick();
            cmp_cnt++;
            if (obs_vec() !== exp_vec() || $countones(m_grant) > 1) begin
                fail_cnt++; $display("FAIL rnd_c%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all();
        test_timeout();
        test_withdraw();
        test_error();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/abus_grant_ctrl.md
# abus_grant_ctrl

Sequential arbitration controller placed directly downstream of the combinational `abus_rr` round-robin arbiter. It drives `abus_rr` with the live master requests and a rotating one-hot priority, then registers the returned grant. It holds that grant for the whole bus transaction and rotates priority on release. Masters see a stable, registered, one-hot ownership signal instead of the combinational arbiter output.

## Interface
Parameters:
- `N`, 8, number of bus masters (≥2); width of every request/grant vector.
- `HOLD_MAX`, 16, maximum number of cycles a master may own the bus before forced release (≥2).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `m_req`  in  N  per-master request level; held high until the transaction is done.
- `m_last`  in  N  per-master last-beat flag; only the bit of the current owner is used.
- `rr_req`  out  N  request vector to `abus_rr.req`.
- `rr_prio`  out  N  one-hot priority vector to `abus_rr.prio`, registered.
- `rr_grant`  in  N  grant vector from `abus_rr.grant`, combinational.
- `m_grant`  out  N  registered one-hot bus ownership; all-zero when the bus is free.
- `bus_busy`  out  1  high while in state GRANT.
- `timeout`  out  1  one-cycle pulse on forced release at `HOLD_MAX`.
- `grant_err`  out  1  one-cycle pulse when `rr_grant` is non-zero and not one-hot in IDLE.

## Operation
- **States:** IDLE, GRANT, RELEASE (2-bit encoding); reset state IDLE.
- **Reset values:**
  - `m_grant` = 0
  - `rr_prio` = 1 (master 0 highest)
  - `bus_busy` = 0, `timeout` = 0, `grant_err` = 0
  - hold counter = 0
- **`rr_req` (combinational):**
  - IDLE: `rr_req` = `m_req`.
  - GRANT and RELEASE: `rr_req` = 0.
- **IDLE:**
  - `rr_grant` one-hot: `m_grant` <= `rr_grant`, counter <= 0, go to GRANT.
  - `rr_grant` = 0: stay in IDLE.
  - `rr_grant` non-zero but not one-hot: stay in IDLE, pulse `grant_err`, `m_grant` unchanged (0).
- **GRANT:** owner = `m_grant`; counter increments every cycle. Release conditions, evaluated in priority order:
  1. `m_last & m_grant` non-zero: normal end.
  2. `m_req & m_grant` = 0: owner withdrew, normal end.
  3. counter = `HOLD_MAX`-1: forced end; `timeout` pulses in the cycle after the edge.
- **On release edge:**
  - `m_grant` <= 0
  - `rr_prio` <= `m_grant` rotated left by 1 (bit N-1 wraps to bit 0)
  - go to RELEASE
- **RELEASE:** single dead cycle; unconditionally go to IDLE.
- **Priority rule:** `rr_prio` changes only on release, so it is always exactly one-hot.
- **Counter:** width `$clog2(HOLD_MAX)`; never wraps, because release occurs at `HOLD_MAX`-1.
- **Non-owner `m_last` bits:** ignored.
- **Simultaneous conditions:** `m_last` asserted on the timeout cycle counts as a normal end; `timeout` stays low.
- **Reset mid-operation:** `rst` high clears all state and outputs immediately, without waiting for `clk`; an in-flight transaction is abandoned.

## Timing
- **Grant latency:** request present in IDLE cycle k -> `m_grant` and `bus_busy` high in cycle k+1.
- **Ownership duration:**
  - Minimum 1 cycle (`m_last` in the first GRANT cycle).
  - Maximum `HOLD_MAX` cycles.
- **Release:** `m_last` sampled high in cycle t -> `m_grant` = 0 in cycle t+1 (RELEASE) -> IDLE in t+2 -> next `m_grant` visible in t+3.
- **Back-to-back masters:** grant edges are spaced (ownership cycles + 2).
- **Output timing:**
  - `m_grant`, `rr_prio`, `bus_busy`, `timeout`, `grant_err` are registered.
  - `rr_req` is combinational from state and `m_req`.
- **Combinational loop:** none (`rr_grant` -> register only).

## Test plan
1. **Reset:** assert `rst` asynchronously mid-cycle -> `m_grant`=0x00, `rr_prio`=0x01, `bus_busy`=0, `timeout`=0 immediately.
2. **Single master:** `m_req`=0x04 held, `m_last`[2] high on the 3rd GRANT cycle -> `m_grant`=0x04 one cycle after the request, for exactly 3 cycles; then 0x00, `rr_prio`=0x08.
3. **All masters:** `m_req`=0xFF, each owner asserts `m_last` on its first GRANT cycle -> `m_grant` sequence 0x01, 0x02, …, 0x80, 0x01, each grant 3 cycles apart; `m_grant` always one-hot or zero.
4. **Timeout:** `HOLD_MAX`=16, `m_req`=0x02 held, `m_last` never asserted -> `m_grant`=0x02 for 16 cycles, then `timeout` pulses 1 cycle, `rr_prio`=0x04; `m_last` on cycle 16 instead -> `timeout` stays 0.
5. **Withdrawal and fairness:** owner 0x10 drops `m_req` in its 2nd cycle while `m_req`=0x11 -> release with no timeout, `rr_prio`=0x20; next grant goes to 0x01.
6. **Error path:** `rr_grant` driven directly to 0x03 in IDLE -> `grant_err` pulses 1 cycle, `m_grant` stays 0x00; separately, `rst` asserted during GRANT -> `m_grant`=0 and state IDLE on the next observed cycle.
